mem_port_arbiter: RTL

- Shares one single-ported unified memory between instruction fetch (IF stage, read-only) and the load/store unit (MEM stage, read/write).
- Sequences each access as a multi-cycle request/ready transaction and returns data to the owning requester.
- Raises per-requester stall signals toward the hazard unit.
- Bounds fetch starvation and memory hang time.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Purpose : shared types and constants for the unified-memory port arbiter.
// Latency : n/a (types, constants and one helper function only).
// Backpressure: n/a.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_LS = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    // Full-word byte enable, used for fetches and loads
    localparam logic [3:0] BMASK_WORD = 4'hF;

    // Instruction fetches always access the whole aligned word
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported memory between instruction fetch and load/store.
// Latency : request sampled at edge N -> o_mem_req in cycle N+1 -> valid in N+2 with zero-wait memory.
// Backpressure: requesters hold req/fields until their valid pulse; the memory stretches a grant via i_mem_ready.
//
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_if_req/i_if_addr -> o_if_rdata/o_if_valid      : fetch requester
//   i_ls_req/wren/addr/wdata/bmask -> o_ls_rdata/valid : load/store requester
//   o_mem_req/wren/addr/wdata/bmask, i_mem_ready/rdata : memory side
//   o_stall_if, o_stall_ls : hazard-unit stalls;  o_err : sticky timeout flag
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_LS_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_valid,
    input  logic        i_ls_req,
    input  logic        i_ls_wren,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_bmask,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_valid,
    output logic        o_mem_req,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall_if,
    output logic        o_stall_ls,
    output logic        o_err
);

    localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [STREAK_W-1:0] r_streak;
    logic [TMO_W-1:0]    r_tmo_cnt;

    logic                r_mem_req;
    logic                r_mem_wren;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_bmask;
    logic [31:0]         r_if_rdata;
    logic                r_if_valid;
    logic [31:0]         r_ls_rdata;
    logic                r_ls_valid;
    logic                r_err;

    logic                w_in_grant;
    logic                w_tmo_hit;
    logic                w_done;
    logic                w_grant_if;
    logic                w_grant_ls;
    req_id_e             w_owner;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // LS wins ties (older instruction) until the streak limit is hit
                if (i_ls_req && (!i_if_req || (r_streak < STREAK_MAX))) begin
                    w_state_nxt = GRANT_LS;
                end else if (i_if_req) begin
                    w_state_nxt = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_LS: begin
                if (i_mem_ready || w_tmo_hit) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: decoded control outputs
    // ---------------------------------------------------------------
    always_comb begin
        w_in_grant = (r_state == GRANT_IF) || (r_state == GRANT_LS);
        w_owner    = (r_state == GRANT_IF) ? REQ_IF : REQ_LS;
        // Abort on the last allowed grant cycle if memory is still silent
        w_tmo_hit  = w_in_grant && !i_mem_ready && (r_tmo_cnt == TMO_LAST);
        w_done     = w_in_grant && (i_mem_ready || w_tmo_hit);
        w_grant_if = (r_state == IDLE) && (w_state_nxt == GRANT_IF);
        w_grant_ls = (r_state == IDLE) && (w_state_nxt == GRANT_LS);
    end

    // ---------------------------------------------------------------
    // Memory-side request registers: loaded on grant entry, held until done
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mem_req   <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_bmask <= '0;
        end else if (w_grant_if) begin
            r_mem_req   <= 1'b1;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= word_align(i_if_addr);
            r_mem_wdata <= '0;
            r_mem_bmask <= BMASK_WORD;
        end else if (w_grant_ls) begin
            r_mem_req   <= 1'b1;
            r_mem_wren  <= i_ls_wren;
            r_mem_addr  <= i_ls_addr;
            r_mem_wdata <= i_ls_wdata;
            r_mem_bmask <= i_ls_wren ? i_ls_bmask : BMASK_WORD;
        end else if (w_done) begin
            r_mem_req   <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Response registers: valid pulses during RESP only
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_if_rdata <= '0;
            r_if_valid <= 1'b0;
            r_ls_rdata <= '0;
            r_ls_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_ls_valid <= 1'b0;
            if (w_done) begin
                if (w_owner == REQ_IF) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= w_tmo_hit ? 32'h0 : i_mem_rdata;
                end else begin
                    r_ls_valid <= 1'b1;
                    // Stores return nothing; keep the last load value visible
                    if (!r_mem_wren) begin
                        r_ls_rdata <= w_tmo_hit ? 32'h0 : i_mem_rdata;
                    end
                end
            end
            if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Fetch-starvation streak and memory timeout counters
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant_if || !i_if_req) begin
                r_streak <= '0;
            end else if (w_grant_ls && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tmo_cnt <= '0;
        end else if (w_grant_if || w_grant_ls) begin
            r_tmo_cnt <= '0;
        end else if (w_in_grant && !i_mem_ready && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_wren  = r_mem_wren;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_bmask = r_mem_bmask;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_ls_rdata  = r_ls_rdata;
    assign o_ls_valid  = r_ls_valid;
    assign o_err       = r_err;
    assign o_stall_if  = i_if_req & ~r_if_valid;
    assign o_stall_ls  = i_ls_req & ~r_ls_valid;

endmodule
